sphere_contact_collector: RTL

// Sits directly downstream of the sphere-sphere collision stage and captures each result on the rising edge of its done flag.

---
 rtl/sphere_contact_collector_if.sv | 31 +++
 rtl/sphere_contact_collector.sv | 136 +++++++++++++
 2 files changed

// File: rtl/sphere_contact_collector_if.sv
// Bundle for sphere_contact_collector: collision-stage result bus plus the
// 9-word valid/ready contact stream.
interface sphere_contact_collector_if;
  logic        in_done;
  logic        in_ret;
  logic [31:0] in_cx;
  logic [31:0] in_cy;
  logic [31:0] in_cz;
  logic [31:0] in_nx;
  logic [31:0] in_ny;
  logic [31:0] in_nz;
  logic [31:0] in_depth;
  logic [31:0] in_g1;
  logic [31:0] in_g2;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;

  modport master (
    output in_done, in_ret, in_cx, in_cy, in_cz, in_nx, in_ny, in_nz,
           in_depth, in_g1, in_g2, out_ready,
    input  out_data, out_valid, out_last
  );

  modport slave (
    input  in_done, in_ret, in_cx, in_cy, in_cz, in_nx, in_ny, in_nz,
           in_depth, in_g1, in_g2, out_ready,
    output out_data, out_valid, out_last
  );
endinterface

// File: rtl/sphere_contact_collector.sv
// Captures sphere-sphere collision results on the rising edge of done, queues
// hits in a FIFO and streams each one as 9 float32/ID words under valid/ready.
module sphere_contact_collector #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  sphere_contact_collector_if.slave bus,
  input  logic                     clear_stats,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         hit_count,
  output logic [CNT_W-1:0]         miss_count,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     overflow
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL     = (PTR_W + 1)'(DEPTH);
  localparam logic [3:0]       LAST_IDX = 4'd8;

  // Word 0 is g1, word 8 is depth: stream order equals packed index order.
  typedef logic [8:0][31:0] entry_t;
  typedef enum logic {IDLE, SEND} state_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  state_t           state;
  logic [3:0]       idx;
  logic             done_q;

  logic             cap;
  logic             pop;
  logic             hit;
  logic             drop;
  logic             miss;
  logic [PTR_W:0]   count_next;
  entry_t           new_entry;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // NOTE: combinational logic uses blocking '=' with every output given a
  // value on every path, so no latch can be inferred.
  always_comb begin
    cap  = bus.in_done & ~done_q;
    pop  = (state == SEND) & bus.out_ready & (idx == LAST_IDX);
    // A pop in the same cycle frees a slot for a capture into a full FIFO.
    hit  = cap & bus.in_ret & ((fifo_count != FULL) | pop);
    drop = cap & bus.in_ret & ~hit;
    miss = cap & ~bus.in_ret;
    count_next = fifo_count + {{PTR_W{1'b0}}, hit} - {{PTR_W{1'b0}}, pop};
    new_entry    = '0;
    new_entry[0] = bus.in_g1;
    new_entry[1] = bus.in_g2;
    new_entry[2] = bus.in_cx;
    new_entry[3] = bus.in_cy;
    new_entry[4] = bus.in_cz;
    new_entry[5] = bus.in_nx;
    new_entry[6] = bus.in_ny;
    new_entry[7] = bus.in_nz;
    new_entry[8] = bus.in_depth;
  end

  assign bus.out_valid = (state == SEND);
  assign bus.out_last  = (state == SEND) && (idx == LAST_IDX);
  assign bus.out_data  = (state == SEND) ? mem[rd_ptr][idx] : '0;

  // NOTE: the entry storage has no reset; validity is tracked by the
  // pointers and fifo_count, which are reset.
  always_ff @(posedge clk) begin
    if (hit) mem[wr_ptr] <= new_entry;
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update
  // from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q     <= 1'b1;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      state      <= IDLE;
      idx        <= '0;
    end else begin
      done_q     <= bus.in_done;
      fifo_count <= count_next;
      if (hit) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case (state)
        IDLE: begin
          if (fifo_count != '0) begin
            state <= SEND;
            idx   <= '0;
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (count_next == '0) state <= IDLE;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Statistics: clear has priority over any same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (clear_stats) begin
      hit_count  <= '0;
      miss_count <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (hit)  hit_count  <= sat_inc(hit_count);
      if (miss) miss_count <= sat_inc(miss_count);
      if (drop) begin
        drop_count <= sat_inc(drop_count);
        overflow   <= 1'b1;
      end
    end
  end

endmodule
